// File: rtl/puf_pkg.sv
// Shared types and helpers for the arbiter-PUF challenge/response engine.
package puf_pkg;

  // Widest LFSR the helper below can step; the engine casts down to its STAGES.
  localparam int LFSR_MAX = 64;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    SAMPLE,
    RELAX,
    DECIDE,
    DONE
  } puf_state_t;

  // One Galois step: shift right, and fold in the tap mask when a one falls out.
  function automatic logic [LFSR_MAX-1:0] lfsr_next(input logic [LFSR_MAX-1:0] cur,
                                                    input logic [LFSR_MAX-1:0] taps);
    if (cur[0]) begin
      return (cur >> 1) ^ taps;
    end
    return cur >> 1;
  endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Challenge generator: STAGES-wide Galois LFSR with load and advance controls.
// A zero seed is replaced by 1 so the register never locks up at all-zeros.
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int                STAGES = 16,
  parameter logic [STAGES-1:0] TAPS   = 16'hB400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [STAGES-1:0] seed,
  output logic [STAGES-1:0] state
);

  // Load wins over advance; otherwise the register holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? STAGES'(1) : seed;
    end else if (advance) begin
      state <= STAGES'(lfsr_next(LFSR_MAX'(state), LFSR_MAX'(TAPS)));
    end
  end

endmodule

// File: rtl/arbiter_puf_engine.sv
// Arbiter-PUF controller: launches the delay chain VOTES times per response bit,
// majority-votes the synchronised arbiter output, flags non-unanimous bits and
// shifts the result MSB-first into a RESP_BITS-wide response word.
module arbiter_puf_engine
  import puf_pkg::*;
#(
  parameter int                STAGES        = 16,
  parameter int                RESP_BITS     = 8,
  parameter int                VOTES         = 5,
  parameter int                SETTLE_CYCLES = 4,
  parameter logic [STAGES-1:0] TAPS          = 16'hB400
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [STAGES-1:0]    seed,
  input  logic                 abort,
  input  logic                 resp_ready,
  input  logic                 arb_in,
  output logic                 launch,
  output logic [STAGES-1:0]    chal_out,
  output logic [RESP_BITS-1:0] resp_data,
  output logic [RESP_BITS-1:0] unstable,
  output logic                 resp_valid,
  output logic                 busy
);

  localparam int VW = $clog2(VOTES + 1);
  localparam int BW = $clog2(RESP_BITS + 1);
  localparam int TW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [VW-1:0] VOTES_C = VW'(VOTES);
  localparam logic [VW-1:0] HALF_C  = VW'(VOTES / 2);
  localparam logic [BW-1:0] LAST_B  = BW'(RESP_BITS - 1);
  localparam logic [TW-1:0] LAST_T  = TW'(SETTLE_CYCLES - 1);

  puf_state_t        state;
  logic              sync1;
  logic              arb_s;
  logic [VW-1:0]     ones;
  logic [VW-1:0]     votes;
  logic [BW-1:0]     bits;
  logic [TW-1:0]     timer;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic [STAGES-1:0] lfsr_state;
  logic              vote_bit;
  logic              vote_mixed;

  // The challenge only moves in DECIDE, when launch is already low.
  assign lfsr_load  = (state == IDLE) && start && !abort;
  assign lfsr_adv   = (state == DECIDE) && !abort;
  assign vote_bit   = (ones > HALF_C);
  assign vote_mixed = (ones != '0) && (ones != VOTES_C);
  assign chal_out   = busy ? lfsr_state : '0;

  puf_lfsr #(
    .STAGES (STAGES),
    .TAPS   (TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (seed),
    .state   (lfsr_state)
  );

  // Two-flop synchroniser for the arbiter output, which is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      arb_s <= 1'b0;
    end else begin
      sync1 <= arb_in;
      arb_s <= sync1;
    end
  end

  // Control FSM with registered outputs; abort overrides everything and wipes the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      launch     <= 1'b0;
      resp_data  <= '0;
      unstable   <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      ones       <= '0;
      votes      <= '0;
      bits       <= '0;
      timer      <= '0;
    end else if (abort) begin
      state      <= IDLE;
      launch     <= 1'b0;
      resp_data  <= '0;
      unstable   <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      ones       <= '0;
      votes      <= '0;
      bits       <= '0;
      timer      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ones      <= '0;
            votes     <= '0;
            bits      <= '0;
            timer     <= '0;
            resp_data <= '0;
            unstable  <= '0;
            busy      <= 1'b1;
            launch    <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (timer == LAST_T) begin
            state <= SAMPLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        SAMPLE: begin
          ones   <= ones + VW'(arb_s);
          votes  <= votes + VW'(1);
          timer  <= '0;
          launch <= 1'b0;
          state  <= RELAX;
        end
        RELAX: begin
          if (timer == LAST_T) begin
            if (votes < VOTES_C) begin
              launch <= 1'b1;
              state  <= LAUNCH;
            end else begin
              state <= DECIDE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DECIDE: begin
          resp_data <= (resp_data << 1) | RESP_BITS'(vote_bit);
          unstable  <= (unstable << 1) | RESP_BITS'(vote_mixed);
          ones      <= '0;
          votes     <= '0;
          bits      <= bits + BW'(1);
          if (bits == LAST_B) begin
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            launch <= 1'b1;
            state  <= LAUNCH;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_puf_engine.sv
// Self-checking bench for arbiter_puf_engine: a timeline model derived from the
// per-vote / per-bit cycle arithmetic is compared against the DUT every cycle,
// alongside hand-computed literal expectations for each directed scenario.
module tb_arbiter_puf_engine;

  localparam int          STAGES    = 16;
  localparam int          RESP_BITS = 8;
  localparam int          VOTES     = 5;
  localparam int          SETTLE    = 4;
  localparam logic [15:0] TAPS      = 16'hB400;
  localparam int          PV        = 2 * SETTLE + 2;
  localparam int          PB        = VOTES * PV + 1;
  localparam int          TOTAL     = RESP_BITS * PB;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic                 clk        = 1'b0;
  logic                 rst_n      = 1'b0;
  logic                 start      = 1'b0;
  logic                 abort      = 1'b0;
  logic                 resp_ready = 1'b0;
  logic                 arb_in     = 1'b0;
  logic [STAGES-1:0]    seed       = '0;
  logic                 launch;
  logic [STAGES-1:0]    chal_out;
  logic [RESP_BITS-1:0] resp_data;
  logic [RESP_BITS-1:0] unstable;
  logic                 resp_valid;
  logic                 busy;

  int n_compared = 0;
  int n_mismatch = 0;

  logic [VOTES-1:0] pat = '1;

  int                m_mode = M_IDLE;
  int                m_t    = 0;
  logic [15:0]       m_seed = 16'h0001;
  logic              m_bit  = 1'b0;
  logic              m_ubit = 1'b0;
  logic [RESP_BITS-1:0] m_data = '0;
  logic [RESP_BITS-1:0] m_unst = '0;

  always #5 clk = ~clk;

  arbiter_puf_engine #(
    .STAGES        (STAGES),
    .RESP_BITS     (RESP_BITS),
    .VOTES         (VOTES),
    .SETTLE_CYCLES (SETTLE),
    .TAPS          (TAPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .abort      (abort),
    .resp_ready (resp_ready),
    .arb_in     (arb_in),
    .launch     (launch),
    .chal_out   (chal_out),
    .resp_data  (resp_data),
    .unstable   (unstable),
    .resp_valid (resp_valid),
    .busy       (busy)
  );

  // Word holding k copies of bit b, oldest in the highest position.
  function automatic logic [RESP_BITS-1:0] fill_word(input int k, input logic b);
    logic [RESP_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < k; i++) w = (w << 1) | RESP_BITS'(b);
    return w;
  endfunction

  // Challenge presented for bit k: seed stepped k times by the Galois rule.
  function automatic logic [15:0] chal_at(input logic [15:0] s, input int k);
    logic [15:0] x;
    x = s;
    for (int i = 0; i < k; i++) x = x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    return x;
  endfunction

  // Transaction-level model: idle / running (cycle index since accept) / done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE;
      m_data <= '0;
      m_unst <= '0;
    end else if (abort) begin
      m_mode <= M_IDLE;
      m_data <= '0;
      m_unst <= '0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          m_mode <= M_RUN;
          m_t    <= 0;
          m_seed <= (seed == 16'h0) ? 16'h0001 : seed;
          m_bit  <= ($countones(pat) * 2 > VOTES);
          m_ubit <= ($countones(pat) != 0) && ($countones(pat) != VOTES);
          m_data <= '0;
          m_unst <= '0;
        end
        M_RUN: if (m_t == TOTAL - 1) begin
          m_mode <= M_DONE;
          m_data <= fill_word(RESP_BITS, m_bit);
          m_unst <= fill_word(RESP_BITS, m_ubit);
        end else begin
          m_t <= m_t + 1;
        end
        default: if (resp_ready) m_mode <= M_IDLE;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: derive the expected outputs from the model and compare.
  task automatic compare_loop();
    int k, r;
    logic e_launch, e_busy, e_valid;
    logic [15:0] e_chal;
    logic [RESP_BITS-1:0] e_data, e_unst;
    forever begin
      @(negedge clk);
      e_launch = 1'b0; e_busy = 1'b0; e_valid = 1'b0; e_chal = '0;
      e_data = m_data; e_unst = m_unst;
      if (m_mode == M_RUN) begin
        k = m_t / PB;
        r = m_t % PB;
        e_launch = (r != PB - 1) && ((r % PV) < SETTLE + 2);
        e_busy   = 1'b1;
        e_chal   = chal_at(m_seed, k);
        e_data   = fill_word(k, m_bit);
        e_unst   = fill_word(k, m_ubit);
      end else if (m_mode == M_DONE) begin
        e_busy  = 1'b1;
        e_valid = 1'b1;
        e_chal  = chal_at(m_seed, RESP_BITS);
      end
      check_output("model_launch", 32'(launch), 32'(e_launch));
      check_output("model_busy", 32'(busy), 32'(e_busy));
      check_output("model_valid", 32'(resp_valid), 32'(e_valid));
      check_output("model_chal", 32'(chal_out), 32'(e_chal));
      check_output("model_data", 32'(resp_data), 32'(e_data));
      check_output("model_unstable", 32'(unstable), 32'(e_unst));
    end
  endtask

  // Plays the chain: on each launch rise present the next vote value, return low while launch is low.
  task automatic arb_driver();
    int   idx;
    logic prev;
    idx = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy !== 1'b1) idx = 0;
      if (launch === 1'b1 && !prev) begin
        arb_in = pat[idx];
        idx = (idx + 1) % VOTES;
      end else if (launch !== 1'b1) begin
        arb_in = 1'b0;
      end
      prev = (launch === 1'b1);
    end
  endtask

  // Pulse start with the given seed; returns on the first negedge after acceptance.
  task automatic apply_stimulus(input logic [15:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles until resp_valid (bounded) while measuring launch pulses and challenges.
  task automatic wait_valid(output int cyc, output int rises, output int bad_w,
                            output logic [15:0] c0, output logic [15:0] c1, output logic [15:0] c2);
    int   run;
    logic prev;
    run = 0; prev = 1'b0;
    cyc = 0; rises = 0; bad_w = 0; c0 = '0; c1 = '0; c2 = '0;
    while (resp_valid !== 1'b1 && cyc < TOTAL + 100) begin
      if (cyc == 0)      c0 = chal_out;
      if (cyc == PB)     c1 = chal_out;
      if (cyc == 2 * PB) c2 = chal_out;
      if (launch === 1'b1) begin
        if (!prev) rises++;
        run++;
      end else begin
        if (prev && run != 6) bad_w++;
        run = 0;
      end
      prev = (launch === 1'b1);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_output("handshake_valid", 32'(resp_valid), 32'd0);
    check_output("handshake_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc, rises, bad_w;
    logic [15:0] c0, c1, c2;

    // Reset held with start high: nothing moves.
    start = 1'b1;
    repeat (2) @(negedge clk);
    fork
      compare_loop();
      arb_driver();
    join_none
    repeat (2) @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_launch", 32'(launch), 32'd0);
    check_output("reset_chal", 32'(chal_out), 32'd0);
    check_output("reset_valid", 32'(resp_valid), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_reset_busy", 32'(busy), 32'd0);

    // Constant-one arbiter, seed 1.
    pat = 5'b11111;
    apply_stimulus(16'h0001);
    wait_valid(cyc, rises, bad_w, c0, c1, c2);
    check_output("ones_latency", 32'(cyc), 32'd408);
    check_output("ones_data", 32'(resp_data), 32'h0000_00FF);
    check_output("ones_unstable", 32'(unstable), 32'h0000_0000);
    check_output("ones_launch_pulses", 32'(rises), 32'd40);
    check_output("ones_bad_widths", 32'(bad_w), 32'd0);
    check_output("ones_chal0", 32'(c0), 32'h0000_0001);
    check_output("ones_chal1", 32'(c1), 32'h0000_B400);
    check_output("ones_chal2", 32'(c2), 32'h0000_5A00);

    // Backpressure: hold in DONE for 20 cycles with a stray start pulse.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i == 5);
    end
    start = 1'b0;
    check_output("bp_valid", 32'(resp_valid), 32'd1);
    check_output("bp_busy", 32'(busy), 32'd1);
    check_output("bp_data", 32'(resp_data), 32'h0000_00FF);

    // Majority 1,1,0,1,0; start held across the DONE->IDLE handshake, seed 0.
    pat   = 5'b01011;
    seed  = 16'h0000;
    start = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    check_output("start_in_done_ignored", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    resp_ready = 1'b0;
    check_output("held_start_accepted", 32'(busy), 32'd1);
    check_output("zero_seed_chal", 32'(chal_out), 32'h0000_0001);
    wait_valid(cyc, rises, bad_w, c0, c1, c2);
    check_output("maj1_latency", 32'(cyc), 32'd408);
    check_output("maj1_data", 32'(resp_data), 32'h0000_00FF);
    check_output("maj1_unstable", 32'(unstable), 32'h0000_00FF);
    handshake();

    // Majority 0,0,1,0,0.
    pat = 5'b00100;
    apply_stimulus(16'h0000);
    wait_valid(cyc, rises, bad_w, c0, c1, c2);
    check_output("maj0_data", 32'(resp_data), 32'h0000_0000);
    check_output("maj0_unstable", 32'(unstable), 32'h0000_00FF);
    handshake();

    // Abort during the third bit's settle window, then a clean run.
    pat = 5'b11111;
    apply_stimulus(16'h0001);
    repeat (2 * PB + 2) @(negedge clk);
    check_output("pre_abort_launch", 32'(launch), 32'd1);
    check_output("pre_abort_data", 32'(resp_data), 32'h0000_0003);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_launch", 32'(launch), 32'd0);
    check_output("abort_data", 32'(resp_data), 32'd0);
    check_output("abort_valid", 32'(resp_valid), 32'd0);
    apply_stimulus(16'hACE1);
    wait_valid(cyc, rises, bad_w, c0, c1, c2);
    check_output("post_abort_latency", 32'(cyc), 32'd408);
    check_output("post_abort_data", 32'(resp_data), 32'h0000_00FF);
    handshake();

    // Asynchronous reset between edges while in RELAX.
    apply_stimulus(16'h1234);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_busy", 32'(busy), 32'd0);
    check_output("async_chal", 32'(chal_out), 32'd0);
    check_output("async_launch", 32'(launch), 32'd0);
    check_output("async_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("async_after_busy", 32'(busy), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
